// File: rtl/uart_tx_tick.sv
// Tick-paced UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// o_ready is high only in IDLE; the frame waits in SYNC for the next tick so each bit spans one full tick interval.
module uart_tx_tick #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tick,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int               IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             PAR_ON    = (PARITY_EN != 0);
    localparam logic             PAR_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state,    w_state;
    logic [DATA_BITS-1:0]   r_shift,    w_shift;
    logic                   r_parity,   w_parity;
    logic [IDX_W-1:0]       r_bit_idx,  w_bit_idx;
    logic                   r_stop_cnt, w_stop_cnt;
    logic                   r_tx,       w_tx;
    logic                   w_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_parity   <= w_parity;
            r_bit_idx  <= w_bit_idx;
            r_stop_cnt <= w_stop_cnt;
            r_tx       <= w_tx;
        end
    end

    // Parity is captured at acceptance because the shift register is consumed as bits go out.
    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_parity   = r_parity;
        w_bit_idx  = r_bit_idx;
        w_stop_cnt = r_stop_cnt;
        w_tx       = r_tx;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_state  = S_SYNC;
                    w_shift  = i_data;
                    w_parity = (^i_data) ^ PAR_INV;
                end
            end
            S_SYNC: begin
                if (i_tick) begin
                    w_tx    = 1'b0;
                    w_state = S_START;
                end
            end
            S_START: begin
                if (i_tick) begin
                    w_tx      = r_shift[0];
                    w_shift   = r_shift >> 1;
                    w_bit_idx = '0;
                    w_state   = S_DATA;
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (r_bit_idx == LAST_IDX) begin
                        if (PAR_ON) begin
                            w_tx    = r_parity;
                            w_state = S_PARITY;
                        end else begin
                            w_tx       = 1'b1;
                            w_stop_cnt = 1'b0;
                            w_state    = S_STOP;
                        end
                    end else begin
                        w_tx      = r_shift[0];
                        w_shift   = r_shift >> 1;
                        w_bit_idx = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (i_tick) begin
                    w_tx       = 1'b1;
                    w_stop_cnt = 1'b0;
                    w_state    = S_STOP;
                end
            end
            S_STOP: begin
                if (i_tick) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_stop_cnt = 1'b1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
            end
        endcase
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_busy  = ~o_ready;
    assign o_tx    = r_tx;
    assign o_done  = w_done;

endmodule
